// File: rtl/lsu_pkg.sv
// LSU shared definitions: op codes, funct3 sizes, FSM states.
// Helpers decode access size and alignment from funct3/addr.
package lsu_pkg;

  localparam logic [1:0] OP_ALU   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

  // Reserved funct3 codes (011/110/111) fall into the word bucket.
  function automatic size_e f3_size(
    input logic [2:0] f3
  );
    size_e s;
    unique case (f3[1:0])
      2'b00:   s = SZ_B;
      2'b01:   s = SZ_H;
      default: s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic misaligned(
    input size_e      s,
    input logic [1:0] a
  );
    logic m;
    unique case (s)
      SZ_H:    m = a[0];
      SZ_W:    m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load alignment: picks byte/half lane from a memory word
// by addr[1:0] and sign- or zero-extends it per funct3.
import lsu_pkg::*;

module lsu_ld_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sgn;

  always_comb begin
    byte_v = 8'h00;
    unique case (addr)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = 8'h00;
    endcase
  end

  assign half_v = addr[1] ? rdata[31:16] : rdata[15:0];

  // funct3[2] marks the unsigned variants (BU/HU).
  assign sgn = ~funct3[2];

  always_comb begin
    ld_data = rdata;
    unique case (f3_size(funct3))
      SZ_B: ld_data = {{24{sgn & byte_v[7]}}, byte_v};
      SZ_H: ld_data = {{16{sgn & half_v[15]}}, half_v};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts ops from decode, runs a
// req/gnt + rvld memory handshake, writes back to the RF.
// Ports: idu_* (op in), lsu_mem_*/mem_lsu_* (memory),
// lsu_rf_wb_* (writeback), lsu_excp_* (misalign report).
import lsu_pkg::*;

module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        idu_lsu_vld,
  output logic        lsu_idu_rdy,
  input  logic [1:0]  idu_lsu_op,
  input  logic [2:0]  idu_lsu_funct3,
  input  logic [31:0] idu_lsu_addr,
  input  logic [31:0] idu_lsu_sdata,
  input  logic [31:0] idu_lsu_alu_res,
  input  logic [4:0]  idu_lsu_rd,
  output logic        lsu_mem_req,
  input  logic        mem_lsu_gnt,
  output logic        lsu_mem_we,
  output logic [31:0] lsu_mem_addr,
  output logic [31:0] lsu_mem_wdata,
  output logic [3:0]  lsu_mem_be,
  input  logic        mem_lsu_rvld,
  input  logic [31:0] mem_lsu_rdata,
  output logic        lsu_rf_wb_vld,
  output logic [4:0]  lsu_rf_wb_addr,
  output logic [31:0] lsu_rf_wb_data,
  output logic        lsu_excp_vld,
  output logic [31:0] lsu_excp_addr
);

  state_e state, state_n;

  logic [31:0] lat_addr;
  logic [1:0]  lat_off;
  logic [2:0]  lat_f3;
  logic [4:0]  lat_rd;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;

  logic        fire;
  logic        is_mem;
  logic        is_st;
  logic        mis;
  logic        acc_pt;
  logic        acc_mem;
  logic        acc_exc;
  size_e       in_sz;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        ld_done;

  assign lsu_idu_rdy = (state == ST_IDLE);
  assign fire    = idu_lsu_vld & lsu_idu_rdy;
  assign is_st   = (idu_lsu_op == OP_STORE);
  assign is_mem  = is_st | (idu_lsu_op == OP_LOAD);
  assign in_sz   = f3_size(idu_lsu_funct3);
  assign mis     = misaligned(in_sz, idu_lsu_addr[1:0]);
  assign acc_pt  = fire & ~is_mem;
  assign acc_mem = fire & is_mem & ~mis;
  assign acc_exc = fire & is_mem & mis;
  assign ld_done = (state == ST_WAIT) & mem_lsu_rvld;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = idu_lsu_sdata;
    unique case (1'b1)
      in_sz == SZ_B: begin
        st_be    = 4'b0001 << idu_lsu_addr[1:0];
        st_wdata = {4{idu_lsu_sdata[7:0]}};
      end
      in_sz == SZ_H: begin
        st_be    = 4'b0011 << idu_lsu_addr[1:0];
        st_wdata = {2{idu_lsu_sdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = idu_lsu_sdata;
      end
    endcase
  end

  lsu_ld_align u_ld_align (
    .rdata   (mem_lsu_rdata),
    .addr    (lat_off),
    .funct3  (lat_f3),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (acc_mem) state_n = ST_REQ;
      ST_REQ: begin
        if (mem_lsu_gnt)
          state_n = lat_we ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: if (mem_lsu_rvld) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr       <= '0;
      lat_off        <= '0;
      lat_f3         <= '0;
      lat_rd         <= '0;
      lat_we         <= 1'b0;
      lat_be         <= '0;
      lat_wdata      <= '0;
      lsu_rf_wb_vld  <= 1'b0;
      lsu_rf_wb_addr <= '0;
      lsu_rf_wb_data <= '0;
      lsu_excp_vld   <= 1'b0;
      lsu_excp_addr  <= '0;
    end else begin
      lsu_rf_wb_vld <= 1'b0;
      lsu_excp_vld  <= 1'b0;
      if (acc_mem) begin
        lat_addr  <= {idu_lsu_addr[31:2], 2'b00};
        lat_off   <= idu_lsu_addr[1:0];
        lat_f3    <= idu_lsu_funct3;
        lat_rd    <= idu_lsu_rd;
        lat_we    <= is_st;
        lat_be    <= is_st ? st_be : 4'b1111;
        lat_wdata <= is_st ? st_wdata : '0;
      end
      // x0 writes are dropped; wb_addr/data keep last value.
      if (acc_pt && idu_lsu_rd != 5'd0) begin
        lsu_rf_wb_vld  <= 1'b1;
        lsu_rf_wb_addr <= idu_lsu_rd;
        lsu_rf_wb_data <= idu_lsu_alu_res;
      end
      if (acc_exc) begin
        lsu_excp_vld  <= 1'b1;
        lsu_excp_addr <= idu_lsu_addr;
      end
      if (ld_done && lat_rd != 5'd0) begin
        lsu_rf_wb_vld  <= 1'b1;
        lsu_rf_wb_addr <= lat_rd;
        lsu_rf_wb_data <= ld_data;
      end
    end
  end

  assign lsu_mem_req   = (state == ST_REQ);
  assign lsu_mem_we    = lat_we;
  assign lsu_mem_addr  = lat_addr;
  assign lsu_mem_wdata = lat_wdata;
  assign lsu_mem_be    = lat_be;

endmodule

// File: tb/tb_lsu.sv
// Directed-vector and random-op bench for the LSU.
// Drives at posedge+1, samples registered outputs there.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        idu_lsu_vld = 1'b0;
  logic        lsu_idu_rdy;
  logic [1:0]  idu_lsu_op = '0;
  logic [2:0]  idu_lsu_funct3 = '0;
  logic [31:0] idu_lsu_addr = '0;
  logic [31:0] idu_lsu_sdata = '0;
  logic [31:0] idu_lsu_alu_res = '0;
  logic [4:0]  idu_lsu_rd = '0;
  logic        lsu_mem_req;
  logic        mem_lsu_gnt = 1'b0;
  logic        lsu_mem_we;
  logic [31:0] lsu_mem_addr;
  logic [31:0] lsu_mem_wdata;
  logic [3:0]  lsu_mem_be;
  logic        mem_lsu_rvld = 1'b0;
  logic [31:0] mem_lsu_rdata = '0;
  logic        lsu_rf_wb_vld;
  logic [4:0]  lsu_rf_wb_addr;
  logic [31:0] lsu_rf_wb_data;
  logic        lsu_excp_vld;
  logic [31:0] lsu_excp_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk             (clk),
    .rst             (rst),
    .idu_lsu_vld     (idu_lsu_vld),
    .lsu_idu_rdy     (lsu_idu_rdy),
    .idu_lsu_op      (idu_lsu_op),
    .idu_lsu_funct3  (idu_lsu_funct3),
    .idu_lsu_addr    (idu_lsu_addr),
    .idu_lsu_sdata   (idu_lsu_sdata),
    .idu_lsu_alu_res (idu_lsu_alu_res),
    .idu_lsu_rd      (idu_lsu_rd),
    .lsu_mem_req     (lsu_mem_req),
    .mem_lsu_gnt     (mem_lsu_gnt),
    .lsu_mem_we      (lsu_mem_we),
    .lsu_mem_addr    (lsu_mem_addr),
    .lsu_mem_wdata   (lsu_mem_wdata),
    .lsu_mem_be      (lsu_mem_be),
    .mem_lsu_rvld    (mem_lsu_rvld),
    .mem_lsu_rdata   (mem_lsu_rdata),
    .lsu_rf_wb_vld   (lsu_rf_wb_vld),
    .lsu_rf_wb_addr  (lsu_rf_wb_addr),
    .lsu_rf_wb_data  (lsu_rf_wb_data),
    .lsu_excp_vld    (lsu_excp_vld),
    .lsu_excp_addr   (lsu_excp_addr)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gd;
    int          rdl;
    logic        x_excp;
    logic        x_wb;
    logic [31:0] x_data;
    logic [3:0]  x_be;
    logic [31:0] x_wdata;
  } vec_t;

  vec_t tbl [16];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic do_op(input vec_t v);
    logic is_mem;
    logic is_st;
    is_st  = (v.op == 2'b10);
    is_mem = is_st || (v.op == 2'b01);
    idu_lsu_vld     = 1'b1;
    idu_lsu_op      = v.op;
    idu_lsu_funct3  = v.f3;
    idu_lsu_addr    = v.addr;
    idu_lsu_sdata   = v.sdata;
    idu_lsu_alu_res = v.alu;
    idu_lsu_rd      = v.rd;
    chk("rdy_accept", {31'd0, lsu_idu_rdy}, 32'd1);
    cyc();
    idu_lsu_vld = 1'b0;
    if (!is_mem) begin
      chk("pt_wb_vld", {31'd0, lsu_rf_wb_vld}, {31'd0, v.x_wb});
      if (v.x_wb) begin
        chk("pt_wb_addr", {27'd0, lsu_rf_wb_addr}, {27'd0, v.rd});
        chk("pt_wb_data", lsu_rf_wb_data, v.x_data);
      end
      chk("pt_excp", {31'd0, lsu_excp_vld}, 32'd0);
    end else if (v.x_excp) begin
      chk("mis_excp_vld", {31'd0, lsu_excp_vld}, 32'd1);
      chk("mis_excp_addr", lsu_excp_addr, v.addr);
      chk("mis_req", {31'd0, lsu_mem_req}, 32'd0);
      chk("mis_rdy", {31'd0, lsu_idu_rdy}, 32'd1);
      chk("mis_wb", {31'd0, lsu_rf_wb_vld}, 32'd0);
      cyc();
      chk("mis_excp_pulse", {31'd0, lsu_excp_vld}, 32'd0);
      chk("mis_req2", {31'd0, lsu_mem_req}, 32'd0);
    end else begin
      for (int i = 0; i < v.gd; i++) begin
        chk("req_hold", {31'd0, lsu_mem_req}, 32'd1);
        chk("req_rdy", {31'd0, lsu_idu_rdy}, 32'd0);
        cyc();
      end
      chk("req", {31'd0, lsu_mem_req}, 32'd1);
      chk("mem_addr", lsu_mem_addr, v.addr & 32'hFFFF_FFFC);
      chk("mem_we", {31'd0, lsu_mem_we}, {31'd0, is_st});
      chk("mem_be", {28'd0, lsu_mem_be}, {28'd0, v.x_be});
      if (is_st) chk("mem_wdata", lsu_mem_wdata, v.x_wdata);
      mem_lsu_gnt = 1'b1;
      cyc();
      mem_lsu_gnt = 1'b0;
      chk("req_drop", {31'd0, lsu_mem_req}, 32'd0);
      if (is_st) begin
        chk("st_rdy", {31'd0, lsu_idu_rdy}, 32'd1);
        chk("st_wb", {31'd0, lsu_rf_wb_vld}, 32'd0);
      end else begin
        for (int i = 0; i < v.rdl; i++) begin
          chk("wait_rdy", {31'd0, lsu_idu_rdy}, 32'd0);
          chk("wait_wb", {31'd0, lsu_rf_wb_vld}, 32'd0);
          cyc();
        end
        mem_lsu_rvld  = 1'b1;
        mem_lsu_rdata = v.rdata;
        cyc();
        mem_lsu_rvld = 1'b0;
        chk("ld_wb_vld", {31'd0, lsu_rf_wb_vld}, {31'd0, v.x_wb});
        if (v.x_wb) begin
          chk("ld_wb_addr", {27'd0, lsu_rf_wb_addr}, {27'd0, v.rd});
          chk("ld_wb_data", lsu_rf_wb_data, v.x_data);
        end
        chk("ld_rdy", {31'd0, lsu_idu_rdy}, 32'd1);
      end
    end
  endtask

  function automatic logic [31:0] mdl_ld(input logic [31:0] d,
                                         input logic [1:0] a,
                                         input logic [2:0] f3);
    logic [31:0] s;
    s = d >> (8 * a);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic mdl_mis(input logic [2:0] f3,
                                   input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      default:        return a != 2'b00;
    endcase
  endfunction

  task automatic mdl_st(input logic [2:0] f3, input logic [1:0] a,
                        input logic [31:0] sd,
                        output logic [3:0] be,
                        output logic [31:0] wd);
    case (f3)
      3'b000, 3'b100: begin
        be = 4'b0001 << a;
        wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      end
      3'b001, 3'b101: begin
        be = a[1] ? 4'b1100 : 4'b0011;
        wd = {sd[15:0], sd[15:0]};
      end
      default: begin
        be = 4'b1111;
        wd = sd;
      end
    endcase
  endtask

  initial begin
    vec_t v;
    //          op    f3      addr          sdata         alu           rd  rdata         gd rdl exc wb  data          be       wdata
    tbl[0]  = '{2'b00, 3'b000, 32'h0,        32'h0,        32'h1234_5678, 5, 32'h0,        0, 0, 0, 1, 32'h1234_5678, 4'hF, 32'h0};
    tbl[1]  = '{2'b00, 3'b000, 32'h0,        32'h0,        32'h1234_5678, 0, 32'h0,        0, 0, 0, 0, 32'h0,        4'hF, 32'h0};
    tbl[2]  = '{2'b11, 3'b010, 32'h0,        32'h0,        32'hDEAD_BEEF, 3, 32'h0,        0, 0, 0, 1, 32'hDEAD_BEEF, 4'hF, 32'h0};
    tbl[3]  = '{2'b10, 3'b000, 32'h1003,     32'h0000_00AB, 32'h0,        9, 32'h0,        3, 0, 0, 0, 32'h0,        4'b1000, 32'hABAB_ABAB};
    tbl[4]  = '{2'b10, 3'b001, 32'h1002,     32'h1234_CAFE, 32'h0,        9, 32'h0,        1, 0, 0, 0, 32'h0,        4'b1100, 32'hCAFE_CAFE};
    tbl[5]  = '{2'b10, 3'b010, 32'h1000,     32'h1122_3344, 32'h0,        9, 32'h0,        0, 0, 0, 0, 32'h0,        4'b1111, 32'h1122_3344};
    tbl[6]  = '{2'b01, 3'b000, 32'h2001,     32'h0,        32'h0,        4, 32'h0000_8000, 0, 2, 0, 1, 32'hFFFF_FF80, 4'hF, 32'h0};
    tbl[7]  = '{2'b01, 3'b100, 32'h2001,     32'h0,        32'h0,        4, 32'h0000_8000, 1, 0, 0, 1, 32'h0000_0080, 4'hF, 32'h0};
    tbl[8]  = '{2'b01, 3'b001, 32'h2002,     32'h0,        32'h0,        6, 32'h8001_0000, 0, 0, 0, 1, 32'hFFFF_8001, 4'hF, 32'h0};
    tbl[9]  = '{2'b01, 3'b101, 32'h2002,     32'h0,        32'h0,        6, 32'h8001_0000, 2, 1, 0, 1, 32'h0000_8001, 4'hF, 32'h0};
    tbl[10] = '{2'b01, 3'b010, 32'h2004,     32'h0,        32'h0,        9, 32'hCAFE_BABE, 0, 5, 0, 1, 32'hCAFE_BABE, 4'hF, 32'h0};
    tbl[11] = '{2'b01, 3'b010, 32'h3002,     32'h0,        32'h0,        9, 32'h0,        0, 0, 1, 0, 32'h0,        4'hF, 32'h0};
    tbl[12] = '{2'b10, 3'b001, 32'h3001,     32'h0,        32'h0,        9, 32'h0,        0, 0, 1, 0, 32'h0,        4'hF, 32'h0};
    tbl[13] = '{2'b01, 3'b010, 32'h2010,     32'h0,        32'h0,        0, 32'h5555_AAAA, 0, 0, 0, 0, 32'h0,        4'hF, 32'h0};
    tbl[14] = '{2'b01, 3'b011, 32'h2008,     32'h0,        32'h0,        2, 32'h89AB_CDEF, 0, 0, 0, 1, 32'h89AB_CDEF, 4'hF, 32'h0};
    tbl[15] = '{2'b01, 3'b000, 32'h2003,     32'h0,        32'h0,        1, 32'h7F00_0000, 0, 0, 0, 1, 32'h0000_007F, 4'hF, 32'h0};

    cyc();
    cyc();
    chk("rst_rdy", {31'd0, lsu_idu_rdy}, 32'd1);
    chk("rst_req", {31'd0, lsu_mem_req}, 32'd0);
    chk("rst_be", {28'd0, lsu_mem_be}, 32'd0);
    chk("rst_we", {31'd0, lsu_mem_we}, 32'd0);
    chk("rst_wb_vld", {31'd0, lsu_rf_wb_vld}, 32'd0);
    chk("rst_wb_addr", {27'd0, lsu_rf_wb_addr}, 32'd0);
    chk("rst_wb_data", lsu_rf_wb_data, 32'd0);
    chk("rst_excp", {31'd0, lsu_excp_vld}, 32'd0);
    chk("rst_excp_addr", lsu_excp_addr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) do_op(tbl[i]);

    // back-to-back passthroughs, then hold of wb_addr/data
    idu_lsu_vld = 1'b1;
    idu_lsu_op = 2'b00;
    idu_lsu_rd = 5'd10;
    idu_lsu_alu_res = 32'hAAAA_0001;
    cyc();
    chk("b2b_vld0", {31'd0, lsu_rf_wb_vld}, 32'd1);
    chk("b2b_data0", lsu_rf_wb_data, 32'hAAAA_0001);
    idu_lsu_rd = 5'd11;
    idu_lsu_alu_res = 32'hBBBB_0002;
    cyc();
    idu_lsu_vld = 1'b0;
    chk("b2b_vld1", {31'd0, lsu_rf_wb_vld}, 32'd1);
    chk("b2b_addr1", {27'd0, lsu_rf_wb_addr}, 32'd11);
    chk("b2b_data1", lsu_rf_wb_data, 32'hBBBB_0002);
    cyc();
    chk("hold_vld", {31'd0, lsu_rf_wb_vld}, 32'd0);
    chk("hold_addr", {27'd0, lsu_rf_wb_addr}, 32'd11);
    chk("hold_data", lsu_rf_wb_data, 32'hBBBB_0002);

    // stray gnt/rvld while idle are ignored
    mem_lsu_gnt = 1'b1;
    mem_lsu_rvld = 1'b1;
    mem_lsu_rdata = 32'h1111_2222;
    cyc();
    cyc();
    mem_lsu_gnt = 1'b0;
    mem_lsu_rvld = 1'b0;
    chk("stray_req", {31'd0, lsu_mem_req}, 32'd0);
    chk("stray_wb", {31'd0, lsu_rf_wb_vld}, 32'd0);
    chk("stray_rdy", {31'd0, lsu_idu_rdy}, 32'd1);

    // reset during WAIT abandons the load
    idu_lsu_vld = 1'b1;
    idu_lsu_op = 2'b01;
    idu_lsu_funct3 = 3'b010;
    idu_lsu_addr = 32'h40;
    idu_lsu_rd = 5'd7;
    cyc();
    idu_lsu_vld = 1'b0;
    mem_lsu_gnt = 1'b1;
    cyc();
    mem_lsu_gnt = 1'b0;
    chk("wait_state", {31'd0, lsu_idu_rdy}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rdy", {31'd0, lsu_idu_rdy}, 32'd1);
    chk("async_rst_req", {31'd0, lsu_mem_req}, 32'd0);
    cyc();
    rst = 1'b0;
    mem_lsu_rvld = 1'b1;
    mem_lsu_rdata = 32'h7777_7777;
    cyc();
    mem_lsu_rvld = 1'b0;
    chk("rst_wait_wb", {31'd0, lsu_rf_wb_vld}, 32'd0);
    chk("rst_wait_rdy", {31'd0, lsu_idu_rdy}, 32'd1);
    cyc();
    chk("rst_wait_wb2", {31'd0, lsu_rf_wb_vld}, 32'd0);
    chk("rst_wait_excp", {31'd0, lsu_excp_vld}, 32'd0);

    // random mix against the reference model
    for (int n = 0; n < 1000; n++) begin
      v.op    = 2'($urandom_range(0, 3));
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = $urandom;
      v.sdata = $urandom;
      v.alu   = $urandom;
      v.rd    = 5'($urandom_range(0, 31));
      v.rdata = $urandom;
      v.gd    = $urandom_range(0, 5);
      v.rdl   = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 0) v.addr[1:0] = 2'b00;
      v.x_be  = 4'hF;
      v.x_wdata = 32'h0;
      v.x_excp = 1'b0;
      v.x_data = 32'h0;
      if (v.op == 2'b01 || v.op == 2'b10) begin
        v.x_excp = mdl_mis(v.f3, v.addr[1:0]);
        if (v.op == 2'b10)
          mdl_st(v.f3, v.addr[1:0], v.sdata, v.x_be, v.x_wdata);
        v.x_wb = (v.op == 2'b01) && !v.x_excp && (v.rd != 0);
        v.x_data = mdl_ld(v.rdata, v.addr[1:0], v.f3);
      end else begin
        v.x_wb = (v.rd != 0);
        v.x_data = v.alu;
      end
      do_op(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
